// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard event controller.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_OVR0  = 8'h00;
    localparam logic [7:0] PS2_OVR1  = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POP   = 2'd1;
    localparam logic [1:0] ST_PARSE = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        POP   = ST_POP,
        PARSE = ST_PARSE,
        EMIT  = ST_EMIT
    } state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

endpackage

// File: rtl/ps2_kbd_ctrl_prefix_timer.sv
// Pending-prefix watchdog: pulses expire_c after TIMEOUT_CYCLES cycles of run without restart.
module ps2_prefix_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clrn,
    input  logic restart,
    input  logic run,
    output logic expire_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_c = run && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (restart || expire_c) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code set 2 sequencer: drains the RX FIFO, strips E0/F0 prefixes, emits key events.
// Build option TYPEMATIC_FILTER_EN drops auto-repeat makes of the currently held key.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    input  logic       ps2_overflow,
    output logic       nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic       any_held,
    output logic [7:0] press_count,
    output logic [1:0] err
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       evt_valid_q, evt_valid_d;
    key_evt_t   evt_q, evt_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_ext_q, held_ext_d;
    logic       any_held_q, any_held_d;
    logic [7:0] press_count_q, press_count_d;
    logic [1:0] err_q, err_d;

    logic restart_c, run_c, expire_c, repeat_c;

    // Every parsed byte restarts the window; it only counts while idle with a prefix pending.
    assign restart_c = (state_q == PARSE);
    assign run_c     = (ext_pend_q || brk_pend_q) && (state_q == IDLE);

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prefix_timer (
        .clk     (clk),
        .clrn    (clrn),
        .restart (restart_c),
        .run     (run_c),
        .expire_c(expire_c)
    );

`ifdef TYPEMATIC_FILTER_EN
    assign repeat_c = !brk_pend_q && any_held_q && (byte_q == held_code_q) &&
                      (ext_pend_q == held_ext_q);
`else
    assign repeat_c = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;
        nextdata_n_d  = nextdata_n_q;
        evt_valid_d   = evt_valid_q;
        evt_d         = evt_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
        any_held_d    = any_held_q;
        press_count_d = press_count_q;
        err_d         = {err_q[1] | ps2_overflow, err_q[0]};

        if (expire_c) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ps2_ready) begin
                    byte_d       = ps2_data;
                    nextdata_n_d = 1'b0;
                    state_d      = POP;
                end
            end
            POP: begin
                nextdata_n_d = 1'b1;
                state_d      = PARSE;
            end
            PARSE: begin
                state_d = IDLE;
                case (byte_q)
                    PS2_EXT: ext_pend_d = 1'b1;
                    PS2_BRK: brk_pend_d = 1'b1;
                    PS2_BAT, PS2_ACK, PS2_ECHO, PS2_PAUSE: ;
                    PS2_OVR0, PS2_OVR1: begin
                        err_d[0]   = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                    default: begin
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        if (!repeat_c) begin
                            evt_d       = '{code: byte_q, ext: ext_pend_q, brk: brk_pend_q};
                            evt_valid_d = 1'b1;
                            state_d     = EMIT;
                        end
                    end
                endcase
            end
            EMIT: begin
                // Accept edge: release the event and update held-key bookkeeping.
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (!evt_q.brk) begin
                        held_code_d   = evt_q.code;
                        held_ext_d    = evt_q.ext;
                        any_held_d    = 1'b1;
                        press_count_d = press_count_q + 8'd1;
                    end else if ((evt_q.code == held_code_q) && (evt_q.ext == held_ext_q)) begin
                        any_held_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q       <= IDLE;
            byte_q        <= '0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            nextdata_n_q  <= 1'b1;
            evt_valid_q   <= 1'b0;
            evt_q         <= '0;
            held_code_q   <= '0;
            held_ext_q    <= 1'b0;
            any_held_q    <= 1'b0;
            press_count_q <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
            nextdata_n_q  <= nextdata_n_d;
            evt_valid_q   <= evt_valid_d;
            evt_q         <= evt_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            any_held_q    <= any_held_d;
            press_count_q <= press_count_d;
            err_q         <= err_d;
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign evt_valid   = evt_valid_q;
    assign evt_code    = evt_q.code;
    assign evt_ext     = evt_q.ext;
    assign evt_break   = evt_q.brk;
    assign held_code   = held_code_q;
    assign held_ext    = held_ext_q;
    assign any_held    = any_held_q;
    assign press_count = press_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: FIFO model, byte-stream event model, per-cycle compare, directed + random streams.
module tb_ps2_kbd_ctrl;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_overflow = 1'b0;
    logic       evt_ready = 1'b0;
    logic       nextdata_n, evt_valid, evt_ext, evt_break, held_ext, any_held;
    logic [7:0] evt_code, held_code, press_count;
    logic [1:0] err;

    ps2_kbd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clrn(clrn), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .ps2_overflow(ps2_overflow), .nextdata_n(nextdata_n), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .held_code(held_code), .held_ext(held_ext), .any_held(any_held),
        .press_count(press_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    int   rdy_mode = 1;
    bit   chk_en = 1'b0;
    ev_t  exp_q[$];
    ev_t  got_q[$];
    logic [7:0] fifo_q[$];

    // Stream-order model: prefixes and held key as seen when each byte is parsed.
    logic       m_ext, m_brk, m_any, m_he;
    logic [7:0] m_hc;
    // Accept-order model of the registered held/count outputs.
    logic       c_any, c_he;
    logic [7:0] c_hc, c_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic void reset_model();
        m_ext = 1'b0; m_brk = 1'b0; m_any = 1'b0; m_he = 1'b0; m_hc = 8'h00;
        c_any = 1'b0; c_he = 1'b0; c_hc = 8'h00; c_cnt = 8'h00;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        bit drop;
        case (b)
            8'hE0: m_ext = 1'b1;
            8'hF0: m_brk = 1'b1;
            8'hAA, 8'hFA, 8'hEE, 8'hE1: ;
            8'h00, 8'hFF: begin m_ext = 1'b0; m_brk = 1'b0; end
            default: begin
                drop = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                drop = !m_brk && m_any && (b == m_hc) && (m_ext == m_he);
`endif
                if (!drop) begin
                    exp_q.push_back({b, m_ext, m_brk});
                    if (!m_brk) begin
                        m_hc = b; m_he = m_ext; m_any = 1'b1;
                    end else if (b == m_hc && m_ext == m_he) begin
                        m_any = 1'b0;
                    end
                end
                m_ext = 1'b0; m_brk = 1'b0;
            end
        endcase
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || evt_valid || !nextdata_n) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #2;
        check({"drain_", name}, 32'(n < 5000), 32'd1);
    endtask

    // Receive FIFO: pops on the edge where nextdata_n is low.
    initial begin
        bit pop;
        forever begin
            @(negedge clk);
            pop = (nextdata_n === 1'b0);
            @(posedge clk);
            #1;
            if (pop) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pops++;
            end
            ps2_ready = (fifo_q.size() > 0);
            if (fifo_q.size() > 0) ps2_data = fifo_q[0];
            else ps2_data = 8'h00;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: evt_ready = 1'b0;
                1: evt_ready = 1'b1;
                default: evt_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Per-cycle compare against the models.
    initial begin
        ev_t e;
        ev_t prev;
        bit  prev_hold;
        bit  prev_ndl;
        prev = '0; prev_hold = 1'b0; prev_ndl = 1'b0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                prev_hold = 1'b0;
                prev_ndl = 1'b0;
                continue;
            end
            check("held_state", {held_code, held_ext, any_held, press_count},
                  {c_hc, c_he, c_any, c_cnt});
            if (!nextdata_n) begin
                check("pop_width", 32'(prev_ndl), 32'd0);
                check("pop_in_emit", 32'(evt_valid), 32'd0);
            end
            if (evt_valid && prev_hold)
                check("evt_stable", {evt_code, evt_ext, evt_break}, prev);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("evt_unexpected", {evt_code, evt_ext, evt_break}, 32'h3FF);
                end else begin
                    e = exp_q.pop_front();
                    check("evt", {evt_code, evt_ext, evt_break}, e);
                    if (!e.brk) begin
                        c_hc = e.code; c_he = e.ext; c_any = 1'b1; c_cnt = c_cnt + 8'd1;
                    end else if (e.code == c_hc && e.ext == c_he) begin
                        c_any = 1'b0;
                    end
                end
                got_q.push_back({evt_code, evt_ext, evt_break});
                prev_hold = 1'b0;
            end else begin
                prev_hold = evt_valid;
            end
            prev = {evt_code, evt_ext, evt_break};
            prev_ndl = !nextdata_n;
        end
    end

    initial begin
        logic [7:0] codes [5];
        logic [7:0] noise [4];
        logic [7:0] cnt0;
        int n;
        codes = '{8'h1C, 8'h32, 8'h21, 8'h75, 8'h6B};
        noise = '{8'hAA, 8'hFA, 8'hEE, 8'hE1};

        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_nextdata_n", 32'(nextdata_n), 32'd1);
        check("rst_evt", {evt_valid, evt_code, evt_ext, evt_break}, 32'd0);
        check("rst_held", {held_code, held_ext, any_held, press_count, err}, 32'd0);
        clrn = 1'b1;
        @(posedge clk); #2;
        chk_en = 1'b1;

        // Press then release of 1C.
        rdy_mode = 1; pops = 0; got_q.delete();
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain("t1");
        check("t1_nev", got_q.size(), 2);
        check("t1_ev0", got_q[0], {8'h1C, 1'b0, 1'b0});
        check("t1_ev1", got_q[1], {8'h1C, 1'b0, 1'b1});
        check("t1_count", press_count, 1);
        check("t1_held", any_held, 0);
        check("t1_pops", pops, 3);

        // Extended key press/release.
        got_q.delete();
        push(8'hE0); push(8'h75);
        drain("t2a");
        check("t2_held", {held_code, held_ext, any_held}, {8'h75, 1'b1, 1'b1});
        push(8'hE0); push(8'hF0); push(8'h75);
        drain("t2b");
        check("t2_ev0", got_q[0], {8'h75, 1'b1, 1'b0});
        check("t2_ev1", got_q[1], {8'h75, 1'b1, 1'b1});
        check("t2_held_off", any_held, 0);
        check("t2_count", press_count, 2);

        // Back-pressure with three bytes queued.
        rdy_mode = 0; pops = 0; got_q.delete();
        push(8'h1C); push(8'h32); push(8'h21);
        repeat (25) @(posedge clk);
        #2;
        check("t3_stall", {evt_valid, evt_code, evt_ext, evt_break}, {1'b1, 8'h1C, 1'b0, 1'b0});
        check("t3_pops", pops, 1);
        check("t3_fifo", fifo_q.size(), 2);
        rdy_mode = 1;
        drain("t3");
        check("t3_ev0", got_q[0], {8'h1C, 1'b0, 1'b0});
        check("t3_ev1", got_q[1], {8'h32, 1'b0, 1'b0});
        check("t3_ev2", got_q[2], {8'h21, 1'b0, 1'b0});
        check("t3_count", press_count, 5);

        // Typematic repeats.
        got_q.delete(); cnt0 = press_count;
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        drain("t4");
`ifdef TYPEMATIC_FILTER_EN
        check("t4_nev", got_q.size(), 2);
        check("t4_count", 32'(press_count - cnt0), 1);
`else
        check("t4_nev", got_q.size(), 4);
        check("t4_count", 32'(press_count - cnt0), 3);
`endif

        // Prefix survives a short gap, expires after a long one.
        got_q.delete();
        push(8'hE0);
        drain("t5a");
        repeat (20) @(posedge clk);
        push(8'h75);
        drain("t5b");
        check("t5_short_gap", got_q[0], {8'h75, 1'b1, 1'b0});
        push(8'hE0);
        drain("t5c");
        repeat (TO + 30) @(posedge clk);
        #2;
        m_ext = 1'b0; m_brk = 1'b0;
        push(8'h75);
        drain("t5d");
        check("t5_timeout", got_q[1], {8'h75, 1'b0, 1'b0});

        // Overrun byte and FIFO overflow flags.
        got_q.delete();
        push(8'hFF);
        drain("t6a");
        check("t6_err0", err, 2'b01);
        push(8'hE0); push(8'hF0); push(8'h00); push(8'h32);
        drain("t6b");
        check("t6_prefix_clr", got_q[0], {8'h32, 1'b0, 1'b0});
        ps2_overflow = 1'b1;
        @(posedge clk); #2;
        ps2_overflow = 1'b0;
        repeat (3) @(posedge clk); #2;
        check("t6_err1", err, 2'b11);

        // Randomized streams with noise bytes and random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(4) == 0) push(noise[$urandom_range(3)]);
            if ($urandom_range(2) == 0) push(8'hE0);
            if ($urandom_range(5) == 0) push(noise[$urandom_range(3)]);
            if ($urandom_range(2) == 0) push(8'hF0);
            push(codes[$urandom_range(4)]);
            if (i % 10 == 9) drain("rand");
        end

        // Reset while an event is waiting.
        rdy_mode = 0;
        push(8'h1C);
        n = 0;
        while (!evt_valid && n < 200) begin
            @(posedge clk); n++;
        end
        #2;
        check("t7_reach_emit", 32'(evt_valid), 32'd1);
        chk_en = 1'b0;
        clrn = 1'b0;
        @(posedge clk); #1;
        check("t7_rst_valid", 32'(evt_valid), 32'd0);
        check("t7_rst_nextdata_n", 32'(nextdata_n), 32'd1);
        check("t7_rst_state", {press_count, any_held, err}, 32'd0);
        clrn = 1'b1;
        reset_model();
        fifo_q.delete();
        rdy_mode = 1;
        @(posedge clk); #2;
        chk_en = 1'b1;
        got_q.delete();
        push(8'h32);
        drain("t7");
        check("t7_after", {got_q[0], press_count}, {8'h32, 1'b0, 1'b0, 8'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
